// File: rtl/sram_device_pkg.sv
// Shared constants and state encoding for the external SRAM model and its controller.
package sram_device_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 17;
  localparam int unsigned SRAM_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StReadWait  = 2'b01,
    StReadDrive = 2'b10,
    StWrite     = 2'b11
  } sram_state_e;

endpackage

// File: rtl/sram_array.sv
// Word storage: one synchronous write port, one combinational read port.
module sram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IdxW-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_device.sv
// Cycle-based model of the external 64-bit SRAM: write-through array, fixed read latency,
// and a tri-state driver that only drives while the read address and w_en stay put.
module sram_device
  import sram_device_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = SRAM_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  input  logic                  sram_w_en,
  input  logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  dq_valid
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = $clog2(READ_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(READ_LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  sram_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  addr_match;
  logic                  mem_we;
  logic                  drive;

  assign addr_match = (sram_address == lat_addr_q);
  assign mem_we     = ~sram_w_en & ~rst;

  // With the address held stable, the live address equals lat_addr, so one read port suffices.
  sram_array #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(sram_address[IdxW-1:0]),
    .wdata_i(sram_dq),
    .raddr_i(sram_address[IdxW-1:0]),
    .rdata_o(rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    rd_data_d  = rd_data_q;
    if (!sram_w_en) begin
      state_d = StWrite;
      cnt_d   = '0;
    end else if (state_q == StIdle || state_q == StWrite || !addr_match) begin
      lat_addr_d = sram_address;
      cnt_d      = CntOne;
      if (READ_LATENCY == 1) begin
        state_d   = StReadDrive;
        rd_data_d = rd_word;
      end else begin
        state_d = StReadWait;
      end
    end else if (state_q == StReadWait) begin
      if (cnt_q == CntLast) begin
        state_d   = StReadDrive;
        rd_data_d = rd_word;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // Release the bus the same cycle the controller moves the address or starts a write.
  assign drive    = (state_q == StReadDrive) && sram_w_en && addr_match;
  assign dq_valid = drive;
  assign sram_dq  = drive ? rd_data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_device.sv
// Directed bench for sram_device: reset, write/read latency, address change, aliasing,
// write abandoning a read, reset during write and during read.
module tb_sram_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [16:0] addr;
  logic        oe;
  logic [63:0] tb_dq;
  wire  [63:0] dq;
  logic        dq_valid;

  int unsigned total  = 0;
  int unsigned passed = 0;

  assign dq = oe ? tb_dq : {64{1'bz}};

  always #5 clk = ~clk;

  sram_device dut (
    .clk         (clk),
    .rst         (rst),
    .sram_dq     (dq),
    .sram_w_en   (w_en),
    .sram_address(addr),
    .dq_valid    (dq_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge, then settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic r, input logic we_n, input logic [16:0] a,
                     input logic drv, input logic [63:0] d);
    rst   = r;
    w_en  = we_n;
    addr  = a;
    oe    = drv;
    tb_dq = d;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    put(1'b1, 1'b1, 17'd0, 1'b0, 64'h0);
    step();
    chk("rst_valid_c0", {63'b0, dq_valid}, 64'd0);
    step();
    chk("rst_valid_c1", {63'b0, dq_valid}, 64'd0);

    // Known contents for later reads.
    put(1'b0, 1'b0, 17'd6, 1'b1, 64'h6666_0000_0000_6666); step();
    put(1'b0, 1'b0, 17'd7, 1'b1, 64'h7777_0000_0000_7777); step();
    put(1'b0, 1'b0, 17'd9, 1'b1, 64'h0);                   step();
    put(1'b0, 1'b0, 17'd3, 1'b1, 64'h3333);                step();

    // Write then read address 5: valid exactly two cycles after the address is presented.
    put(1'b0, 1'b0, 17'd5, 1'b1, 64'hDEADBEEF_CAFEF00D);
    chk("wr5_no_drive", {63'b0, dq_valid}, 64'd0);
    step();
    put(1'b0, 1'b1, 17'd5, 1'b0, 64'h0);
    chk("rd5_c0_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("rd5_c1_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("rd5_c2_valid", {63'b0, dq_valid}, 64'd1);
    chk("rd5_c2_data", dq, 64'hDEADBEEF_CAFEF00D);

    // Holding the address keeps data on the bus (counter saturates).
    step(); step(); step();
    chk("rd5_hold_valid", {63'b0, dq_valid}, 64'd1);
    chk("rd5_hold_data", dq, 64'hDEADBEEF_CAFEF00D);

    // Address change while driving: released in the same cycle, mem[6] two cycles later.
    put(1'b0, 1'b1, 17'd6, 1'b0, 64'h0);
    chk("chg6_c0_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("chg6_c1_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("chg6_c2_valid", {63'b0, dq_valid}, 64'd1);
    chk("chg6_c2_data", dq, 64'h6666_0000_0000_6666);

    // Address 5 for one cycle then 6: nothing driven for the short-lived address.
    put(1'b0, 1'b1, 17'd5, 1'b0, 64'h0);
    chk("brief5_valid", {63'b0, dq_valid}, 64'd0);
    step();
    put(1'b0, 1'b1, 17'd6, 1'b0, 64'h0);
    chk("back6_c0_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("back6_c1_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("back6_c2_valid", {63'b0, dq_valid}, 64'd1);
    chk("back6_c2_data", dq, 64'h6666_0000_0000_6666);

    // Wrap-around: address 1027 aliases word 3.
    put(1'b0, 1'b0, 17'd1027, 1'b1, 64'h1); step();
    put(1'b0, 1'b1, 17'd3, 1'b0, 64'h0);
    step(); step();
    chk("wrap3_valid", {63'b0, dq_valid}, 64'd1);
    chk("wrap3_data", dq, 64'h1);

    // Write abandons a driving read of 7, then the re-read returns the new word.
    put(1'b0, 1'b1, 17'd7, 1'b0, 64'h0);
    step(); step();
    chk("rd7_valid", {63'b0, dq_valid}, 64'd1);
    chk("rd7_data", dq, 64'h7777_0000_0000_7777);
    put(1'b0, 1'b0, 17'd7, 1'b1, 64'h55);
    chk("wr7_released", {63'b0, dq_valid}, 64'd0);
    step();
    put(1'b0, 1'b1, 17'd7, 1'b0, 64'h0);
    chk("rerd7_c0_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("rerd7_c1_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("rerd7_c2_valid", {63'b0, dq_valid}, 64'd1);
    chk("rerd7_c2_data", dq, 64'h55);

    // Reset on the same edge as a write: the write is dropped.
    put(1'b1, 1'b0, 17'd9, 1'b1, 64'hAA);
    step();
    put(1'b0, 1'b1, 17'd9, 1'b0, 64'h0);
    chk("rd9_c0_valid", {63'b0, dq_valid}, 64'd0);
    step(); step();
    chk("rd9_valid", {63'b0, dq_valid}, 64'd1);
    chk("rd9_data", dq, 64'h0);

    // Reset while driving: bus released from the reset edge, read restarts afterwards.
    put(1'b1, 1'b1, 17'd9, 1'b0, 64'h0);
    step();
    chk("rstrd_released", {63'b0, dq_valid}, 64'd0);
    put(1'b0, 1'b1, 17'd6, 1'b0, 64'h0);
    step();
    chk("postrst_c1_valid", {63'b0, dq_valid}, 64'd0);
    step();
    chk("postrst_c2_valid", {63'b0, dq_valid}, 64'd1);
    chk("postrst_c2_data", dq, 64'h6666_0000_0000_6666);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
